div_seq: RTL and testbench

- Multi-cycle restoring divider: a parametrised successor to the ALU's single-cycle combinational divide.
- Supports both signed (DIV) and unsigned (DIVU) operation.
- Adds a start/busy/done handshake, a divide-by-zero flag, and registered results that hold until the next operation.
- Sits beside the ALU; the CPU control FSM stalls on busy and writes HI/LO on done.

---
 rtl/div_seq_if.sv | 18 +
 rtl/div_seq.sv | 76 +++++++
 tb/tb_div_seq.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/div_seq_if.sv
// div_seq_if: request/result bundle between the CPU control and the sequential divider
interface div_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             sign_mode;
    logic [WIDTH-1:0] S;
    logic [WIDTH-1:0] T;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Y_hi;
    logic [WIDTH-1:0] Y_lo;
    logic             N;
    logic             Z;
    logic             div0;
    modport master (output start, sign_mode, S, T, input busy, done, Y_hi, Y_lo, N, Z, div0);
    modport slave (input start, sign_mode, S, T, output busy, done, Y_hi, Y_lo, N, Z, div0);
endinterface

// File: rtl/div_seq.sv
// div_seq: multi-cycle restoring divider, signed/unsigned, with start/busy/done handshake
module div_seq #(
    parameter int WIDTH = 32
) (
    input logic      clk,
    input logic      reset,
    div_seq_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
    state_t           state, state_n;
    logic [WIDTH-1:0] rem, quo, dvs, abs_s, abs_t;
    logic [WIDTH:0]   diff;
    logic [CNT_W-1:0] cnt;
    logic             sn, tn, zd, t_zero;
    assign t_zero   = bus.T == '0;
    assign abs_s    = (bus.sign_mode && bus.S[WIDTH-1]) ? -bus.S : bus.S;
    assign abs_t    = (bus.sign_mode && bus.T[WIDTH-1]) ? -bus.T : bus.T;
    assign diff     = {rem, quo[WIDTH-1]} - {1'b0, dvs};
    assign bus.busy = state != IDLE;
    assign bus.N    = bus.Y_lo[WIDTH-1];
    assign bus.Z    = bus.Y_lo == '0;
    // state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else state <= state_n;
    end
    // next state: a zero divisor skips the iterations and goes straight to the fixup
    always_comb begin
        state_n = state;
        if (state == IDLE && bus.start) state_n = t_zero ? FIX : RUN;
        else if (state == RUN && cnt == CNT_W'(1)) state_n = FIX;
        else if (state == FIX) state_n = IDLE;
    end
    // datapath: load magnitudes, shift/trial-subtract, then apply signs and register results
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.done <= 1'b0;
            bus.div0 <= 1'b0;
            bus.Y_hi <= '0;
            bus.Y_lo <= '0;
            rem      <= '0;
            quo      <= '0;
            dvs      <= '0;
            cnt      <= '0;
            sn       <= 1'b0;
            tn       <= 1'b0;
            zd       <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    sn  <= bus.sign_mode & bus.S[WIDTH-1];
                    tn  <= bus.sign_mode & bus.T[WIDTH-1];
                    zd  <= t_zero;
                    rem <= t_zero ? bus.S : '0;
                    quo <= t_zero ? '1 : abs_s;
                    dvs <= abs_t;
                    cnt <= CNT_W'(WIDTH);
                end
                RUN: begin
                    rem <= diff[WIDTH] ? {rem[WIDTH-2:0], quo[WIDTH-1]} : diff[WIDTH-1:0];
                    quo <= {quo[WIDTH-2:0], ~diff[WIDTH]};
                    cnt <= cnt - 1'b1;
                end
                FIX: begin
                    bus.Y_lo <= (!zd && (sn ^ tn)) ? -quo : quo;
                    bus.Y_hi <= (!zd && sn) ? -rem : rem;
                    bus.div0 <= zd;
                    bus.done <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: scoreboard bench for 32-bit and 8-bit divider instances
module tb_div_seq;
    typedef struct {
        logic [63:0] lo;
        logic [63:0] hi;
        logic        d0;
        int          acc;
        int          lat;
    } exp_t;
    logic clk = 0;
    logic reset = 1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   bc32 = 0;
    int   bc8 = 0;
    exp_t q32[$];
    exp_t q8[$];
    exp_t e32, e8;
    div_seq_if #(.WIDTH(32)) b32();
    div_seq_if #(.WIDTH(8))  b8();
    div_seq #(.WIDTH(32)) u32 (.clk(clk), .reset(reset), .bus(b32));
    div_seq #(.WIDTH(8))  u8  (.clk(clk), .reset(reset), .bus(b8));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    always @(negedge clk) begin
        if (reset) bc32 = 0;
        else begin
            if (b32.busy) bc32++;
            if (b32.done) begin
                if (q32.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL done32_unexpected: got done=1 expected no pending op");
                end else begin
                    e32 = q32.pop_front();
                    chk("y_lo32", 64'(b32.Y_lo), e32.lo);
                    chk("y_hi32", 64'(b32.Y_hi), e32.hi);
                    chk("n32", 64'(b32.N), 64'(e32.lo[31]));
                    chk("z32", 64'(b32.Z), 64'(e32.lo[31:0] == 0));
                    chk("div0_32", 64'(b32.div0), 64'(e32.d0));
                    chk("lat32", 64'(cyc - e32.acc), 64'(e32.lat));
                    chk("busy32", 64'(bc32), 64'(e32.lat));
                end
                bc32 = 0;
            end
        end
    end
    always @(negedge clk) begin
        if (reset) bc8 = 0;
        else begin
            if (b8.busy) bc8++;
            if (b8.done) begin
                if (q8.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL done8_unexpected: got done=1 expected no pending op");
                end else begin
                    e8 = q8.pop_front();
                    chk("y_lo8", 64'(b8.Y_lo), e8.lo);
                    chk("y_hi8", 64'(b8.Y_hi), e8.hi);
                    chk("n8", 64'(b8.N), 64'(e8.lo[7]));
                    chk("z8", 64'(b8.Z), 64'(e8.lo[7:0] == 0));
                    chk("div0_8", 64'(b8.div0), 64'(e8.d0));
                    chk("lat8", 64'(cyc - e8.acc), 64'(e8.lat));
                    chk("busy8", 64'(bc8), 64'(e8.lat));
                end
                bc8 = 0;
            end
        end
    end
    task automatic issue32(input logic sm, input logic [31:0] s, input logic [31:0] t,
                           input logic [31:0] lo, input logic [31:0] hi, input logic d0);
        @(negedge clk);
        b32.start = 1;
        b32.sign_mode = sm;
        b32.S = s;
        b32.T = t;
        @(posedge clk);
        #1;
        q32.push_back('{lo: 64'(lo), hi: 64'(hi), d0: d0, acc: cyc, lat: d0 ? 1 : 33});
        @(negedge clk);
        b32.start = 0;
    endtask
    task automatic issue8(input logic sm, input logic [7:0] s, input logic [7:0] t,
                          input logic [7:0] lo, input logic [7:0] hi);
        @(negedge clk);
        b8.start = 1;
        b8.sign_mode = sm;
        b8.S = s;
        b8.T = t;
        @(posedge clk);
        #1;
        q8.push_back('{lo: 64'(lo), hi: 64'(hi), d0: 1'b0, acc: cyc, lat: 9});
        @(negedge clk);
        b8.start = 0;
    endtask
    task automatic wait32();
        int n = 0;
        while (q32.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (q32.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout32: pending=%0d expected 0", q32.size());
            q32.delete();
        end
    endtask
    task automatic wait8();
        int n = 0;
        while (q8.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (q8.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout8: pending=%0d expected 0", q8.size());
            q8.delete();
        end
    endtask
    task automatic chk_cleared(input string tag);
        chk({tag, "_busy"}, 64'(b32.busy), 0);
        chk({tag, "_done"}, 64'(b32.done), 0);
        chk({tag, "_ylo"}, 64'(b32.Y_lo), 0);
        chk({tag, "_yhi"}, 64'(b32.Y_hi), 0);
        chk({tag, "_n"}, 64'(b32.N), 0);
        chk({tag, "_z"}, 64'(b32.Z), 1);
        chk({tag, "_div0"}, 64'(b32.div0), 0);
    endtask
    initial begin
        int n;
        b32.start = 0; b32.sign_mode = 0; b32.S = 0; b32.T = 0;
        b8.start = 0;  b8.sign_mode = 0;  b8.S = 0;  b8.T = 0;
        repeat (2) @(negedge clk);
        chk_cleared("rst");
        reset = 0;
        issue32(0, 32'd100, 32'd7, 32'd14, 32'd2, 0);
        wait32();
        issue32(1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 0);
        wait32();
        issue32(0, 32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC, 32'd1, 0);
        wait32();
        issue32(0, 32'h00001234, 32'd0, 32'hFFFFFFFF, 32'h00001234, 1);
        wait32();
        issue32(1, 32'h00001234, 32'd0, 32'hFFFFFFFF, 32'h00001234, 1);
        wait32();
        issue32(1, 32'hFFFFFFF0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFF0, 1);
        wait32();
        issue32(0, 32'd9, 32'd3, 32'd3, 32'd0, 0);
        wait32();
        issue32(1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 0);
        wait32();
        issue32(1, 32'd5, 32'hFFFFFFF6, 32'd0, 32'd5, 0);
        wait32();
        issue32(0, 32'd9, 32'd3, 32'd3, 32'd0, 0);
        wait32();
        issue32(0, 32'd1000, 32'd3, 32'd333, 32'd1, 0);
        repeat (9) @(negedge clk);
        q32.delete();
        reset = 1;
        @(negedge clk);
        chk_cleared("abort");
        reset = 0;
        issue32(0, 32'd50, 32'd5, 32'd10, 32'd0, 0);
        wait32();
        issue32(0, 32'd1000, 32'd3, 32'd333, 32'd1, 0);
        repeat (4) @(negedge clk);
        b32.start = 1; b32.S = 32'd5; b32.T = 32'd1;
        @(negedge clk);
        b32.start = 0;
        wait32();
        issue8(0, 8'd200, 8'd15, 8'd13, 8'd5);
        wait8();
        issue8(1, 8'h80, 8'hFF, 8'h80, 8'h00);
        wait8();
        @(negedge clk);
        b8.start = 1; b8.sign_mode = 0; b8.S = 8'd200; b8.T = 8'd15;
        @(posedge clk);
        #1;
        q8.push_back('{lo: 64'd13, hi: 64'd5, d0: 1'b0, acc: cyc, lat: 9});
        @(negedge clk);
        b8.S = 8'd100; b8.T = 8'd7;
        n = 0;
        while (!b8.done && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        q8.push_back('{lo: 64'd14, hi: 64'd2, d0: 1'b0, acc: cyc, lat: 9});
        @(negedge clk);
        b8.start = 0;
        wait8();
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
